upe_sub64_seq: RTL
==================

UPE_SUB64_SEQ -- requirements
Module: upe_sub64_seq

Interface
REQ-001 Parameters SHALL be:
- SLICE_W, default 16, width of the subtract slice processed per cycle.
- SLICES, default 4, number of slices; operand width W = SLICE_W*SLICES.

REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept a request.
- A  in  W  minuend.
- B  in  W  subtrahend.
- borrowin  in  1  borrow into the least-significant slice.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- Out  out  W  A - B - borrowin, modulo 2^W.
- borrowout  out  1  unsigned borrow out of the most-significant slice.
- overflow  out  1  signed (two's-complement) overflow of the result.

REQ-003 The block SHALL have one clock (clk) and a synchronous active-high reset (reset); no other clock or asynchronous input.

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-005 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-006 Accept occurs on a rising edge with in_valid=1 and in_ready=1. At accept:
- A, B and borrowin are captured.
- The slice counter is cleared to 0.
- The state becomes RUN.
REQ-007 A, B and borrowin SHALL be ignored at all edges other than accept; changes during RUN or DONE have no effect.
REQ-008 Each RUN edge SHALL process slice k = counter, LSB first:
- Out[k*SLICE_W +: SLICE_W] = Ak - Bk - borrow_k.
- borrow_0 = captured borrowin.
- borrow_(k+1) = 1 when Ak < Bk + borrow_k (unsigned).
- The counter then increments.
REQ-009 The edge that processes slice SLICES-1 SHALL:
- set borrowout = borrow_SLICES;
- set overflow = (A[W-1] != B[W-1]) AND (Out[W-1] != A[W-1]), using captured A and B;
- move the state to DONE.
REQ-010 Latency: out_valid SHALL rise exactly SLICES edges after the accept edge (4 with defaults).
REQ-011 Out, borrowout and overflow SHALL hold stable while out_valid=1 and out_ready=0; there is no timeout.
REQ-012 A rising edge in DONE with out_ready=1 SHALL return the state to IDLE. No request is accepted on that same edge (in_ready was 0). Minimum request spacing is SLICES+2 cycles.
REQ-013 out_ready SHALL be ignored outside DONE. in_valid SHALL be ignored outside IDLE.
REQ-014 Out bits of slices not yet processed SHALL read 0 during RUN. Out, borrowout and overflow are valid only while out_valid=1.
REQ-015 Arithmetic SHALL be unsigned modulo 2^W. borrowout=1 exactly when A < B + borrowin as (W+1)-bit unsigned values.
REQ-016 Boundary cases:
- B=0 with borrowin=0 SHALL give Out=A, borrowout=0.
- A=B with borrowin=1 SHALL give Out = all ones, borrowout=1.
- A borrow SHALL ripple through every slice without extra latency.

Reset
REQ-017 With reset=1 at a rising edge, the block SHALL set:
- state = IDLE, counter = 0.
- Out = 0, borrowout = 0, overflow = 0.
- out_valid = 0, in_ready = 1 after that edge.
REQ-018 Reset SHALL take priority over accept, slice processing and result handoff in any state.
REQ-019 Reset mid-RUN or mid-DONE SHALL discard the in-flight operation; no partial result is ever presented with out_valid=1.
REQ-020 The first accept after reset SHALL be possible on the first edge with reset=0.

Verification
REQ-021 Basic subtract: A=0x10, B=0x3, borrowin=0, out_ready=1 -> out_valid 4 edges after accept; Out=0xD, borrowout=0, overflow=0.
REQ-022 Wrap: A=0, B=1 -> Out=0xFFFF_FFFF_FFFF_FFFF, borrowout=1, overflow=0.
REQ-023 Borrow ripple: A=0x0001_0000_0000_0000, B=0, borrowin=1 -> Out=0x0000_FFFF_FFFF_FFFF, borrowout=0.
REQ-024 Signed overflow: A=0x8000_0000_0000_0000, B=1 -> Out=0x7FFF_FFFF_FFFF_FFFF, borrowout=0, overflow=1.
REQ-025 Backpressure: hold out_ready=0 for 3 cycles after out_valid and drive A/B to new values during that time -> Out unchanged and in_ready=0 throughout. Raise out_ready -> IDLE on the next edge; the next request is accepted one edge later.
REQ-026 Reset during RUN: assert reset on the 2nd RUN edge -> after that edge out_valid=0, in_ready=1, Out=0, borrowout=0, overflow=0. A subsequent request A=5, B=2 -> Out=3 after 4 edges.

Source files
------------

// File: rtl/upe_sub64_seq.sv
// upe_sub64_seq: multi-cycle subtractor that processes one SLICE_W-bit slice per clock, LSB first
module upe_sub64_seq #(
    parameter int SLICE_W = 16,
    parameter int SLICES  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SLICE_W*SLICES-1:0]  A,
    input  logic [SLICE_W*SLICES-1:0]  B,
    input  logic                       borrowin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*SLICES-1:0]  Out,
    output logic                       borrowout,
    output logic                       overflow
);
    localparam int W  = SLICE_W * SLICES;
    localparam int CW = SLICES > 1 ? $clog2(SLICES) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t              state, next;
    logic [CW-1:0]       cnt;
    logic [W-1:0]        a_q, b_q, res;
    logic                brw, bo_q, ov_q;
    logic [SLICE_W:0]    diff;
    logic                last;
    assign last      = cnt == CW'(SLICES - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign Out       = res;
    assign borrowout = bo_q;
    assign overflow  = ov_q;
    // One slice of the subtraction; the extra top bit is the borrow into the next slice
    always_comb begin
        diff = {1'b0, a_q[cnt*SLICE_W +: SLICE_W]} - {1'b0, b_q[cnt*SLICE_W +: SLICE_W]}
             - {{SLICE_W{1'b0}}, brw};
    end
    // Next-state logic: accept in IDLE, walk the slices in RUN, hand off in DONE
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = in_valid  ? RUN  : IDLE;
            RUN:     next = last      ? DONE : RUN;
            DONE:    next = out_ready ? IDLE : DONE;
            default: next = IDLE;
        endcase
    end
    // State, operand capture and slice-by-slice result accumulation
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            brw   <= 1'b0;
            res   <= '0;
            bo_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && in_valid) begin
                a_q  <= A;
                b_q  <= B;
                brw  <= borrowin;
                cnt  <= '0;
                res  <= '0;
                bo_q <= 1'b0;
                ov_q <= 1'b0;
            end else if (state == RUN) begin
                res[cnt*SLICE_W +: SLICE_W] <= diff[SLICE_W-1:0];
                brw <= diff[SLICE_W];
                cnt <= last ? '0 : cnt + CW'(1);
                if (last) begin
                    bo_q <= diff[SLICE_W];
                    ov_q <= (a_q[W-1] != b_q[W-1]) && (diff[SLICE_W-1] != a_q[W-1]);
                end
            end
        end
    end
endmodule
